// File: rtl/rpn_pkg.sv
// Shared opcode, ASCII and state definitions for the RPN token parser.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_MUL   = 3'd3,
    OP_PRINT = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NUM,
    ST_ISSUE_PUSH,
    ST_ISSUE_OP
  } state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_EQUAL = 8'h3D;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  function automatic logic is_operator(input logic [7:0] b);
    return (b == ASCII_PLUS) || (b == ASCII_MINUS) ||
           (b == ASCII_STAR) || (b == ASCII_EQUAL);
  endfunction

  function automatic op_t byte_to_op(input logic [7:0] b);
    case (b)
      ASCII_PLUS:  return OP_ADD;
      ASCII_MINUS: return OP_SUB;
      ASCII_STAR:  return OP_MUL;
      ASCII_EQUAL: return OP_PRINT;
      default:     return OP_PUSH;
    endcase
  endfunction

endpackage

// File: rtl/rpn_dec_acc.sv
// Decimal accumulate step: acc*10 + digit via shift-add, with exact overflow.
module rpn_dec_acc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             ovf_o
);

  // Four extra bits hold the worst case (2^WIDTH-1)*10 + 9 exactly.
  logic [WIDTH+3:0] exact;

  always_comb begin
    exact = ({4'b0, acc_i} << 3) + ({4'b0, acc_i} << 1) + {{WIDTH{1'b0}}, digit_i};
    acc_o = exact[WIDTH-1:0];
    ovf_o = |exact[WIDTH+3:WIDTH];
  end

endmodule

// File: rtl/rpn_token_parser.sv
// Turns a UART byte stream of RPN tokens into PUSH/operator commands
// offered over a valid/ready handshake.
module rpn_token_parser
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] cmd_value,
  output logic             cmd_ovf,
  output logic             overrun,
  output logic             syntax_err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  op_t              pend_op_q, pend_op_d;
  logic             overrun_q, overrun_d;
  logic             syntax_err_q, syntax_err_d;

  logic [WIDTH-1:0] acc_next;
  logic             acc_next_ovf;

  rpn_dec_acc #(.WIDTH(WIDTH)) u_dec_acc (
    .acc_i   (acc_q),
    .digit_i (rx_data[3:0]),
    .acc_o   (acc_next),
    .ovf_o   (acc_next_ovf)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      pend_op_q    <= OP_PUSH;
      overrun_q    <= 1'b0;
      syntax_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      pend_op_q    <= pend_op_d;
      overrun_q    <= overrun_d;
      syntax_err_q <= syntax_err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    pend_op_d    = pend_op_q;
    overrun_d    = 1'b0;
    syntax_err_d = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = OP_PUSH;
    cmd_value    = '0;
    cmd_ovf      = 1'b0;

    case (state_q)
      ST_IDLE, ST_NUM: begin
        if (rx_ready) begin
          if (is_digit(rx_data)) begin
            acc_d   = acc_next;
            ovf_d   = ovf_q | acc_next_ovf;
            state_d = ST_NUM;
          end else if (is_delim(rx_data)) begin
            if (state_q == ST_NUM) state_d = ST_ISSUE_PUSH;
          end else if (is_operator(rx_data)) begin
            pend_op_d = byte_to_op(rx_data);
            state_d   = (state_q == ST_NUM) ? ST_ISSUE_PUSH : ST_ISSUE_OP;
          end else begin
            syntax_err_d = 1'b1;
            acc_d        = '0;
            ovf_d        = 1'b0;
            pend_op_d    = OP_PUSH;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_ISSUE_PUSH: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_value = acc_q;
        cmd_ovf   = ovf_q;
        overrun_d = rx_ready;
        if (cmd_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          // pend_op of PUSH doubles as "no operator pending".
          state_d = (pend_op_q != OP_PUSH) ? ST_ISSUE_OP : ST_IDLE;
        end
      end
      ST_ISSUE_OP: begin
        cmd_valid = 1'b1;
        cmd_op    = pend_op_q;
        overrun_d = rx_ready;
        if (cmd_ready) begin
          pend_op_d = OP_PUSH;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overrun    = overrun_q;
  assign syntax_err = syntax_err_q;

endmodule

// File: tb/tb_rpn_token_parser.sv
// Directed, table-driven bench for rpn_token_parser (WIDTH=16).
module tb_rpn_token_parser;

  localparam int WIDTH = 16;
  localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, MUL = 3'd3, PRINT = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_value;
  logic             cmd_ovf;
  logic             overrun;
  logic             syntax_err;

  int n_vec  = 0;
  int n_miss = 0;

  rpn_token_parser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_value  (cmd_value),
    .cmd_ovf    (cmd_ovf),
    .overrun    (overrun),
    .syntax_err (syntax_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        rdy;
    logic        crdy;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [15:0] e_val;
    logic        e_ovf;
    logic        e_ovr;
    logic        e_syn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [7:0] d, logic r, logic c,
                              logic ev, logic [2:0] eo, logic [15:0] ex,
                              logic eovf, logic eovr, logic esyn);
    vec_t v;
    v.name = n; v.data = d; v.rdy = r; v.crdy = c;
    v.e_valid = ev; v.e_op = eo; v.e_val = ex;
    v.e_ovf = eovf; v.e_ovr = eovr; v.e_syn = esyn;
    return v;
  endfunction

  function automatic logic [22:0] pack_out();
    return {cmd_valid, cmd_op, cmd_value, cmd_ovf, overrun, syntax_err};
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got {valid,op,value,ovf,ovr,syn}=%0b,%0d,%0d,%0b,%0b,%0b expected %0b,%0d,%0d,%0b,%0b,%0b",
               name, got[22], got[21:19], got[18:3], got[2], got[1], got[0],
               exp[22], exp[21:19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive_cycle(input logic [7:0] d, input logic r, input logic c);
    rx_data = d; rx_ready = r; cmd_ready = c;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; cmd_ready = 1'b0;
    #1;
    check("reset_state", pack_out(), 23'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // "12 " -> PUSH 12
    vecs.push_back(mk("a_1",     "1",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("a_2",     "2",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("a_sp",    " ",   1, 1, 1, PUSH, 12, 0, 0, 0));
    vecs.push_back(mk("a_xfer",  8'h78, 0, 1, 0, PUSH, 0,  0, 0, 0));
    // "3+" -> PUSH 3 then ADD back-to-back
    vecs.push_back(mk("b_3",     "3",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("b_plus",  "+",   1, 1, 1, PUSH, 3,  0, 0, 0));
    vecs.push_back(mk("b_add",   0,     0, 1, 1, ADD,  0,  0, 0, 0));
    vecs.push_back(mk("b_idle",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    // "70000 " -> truncated PUSH 4464 with ovf
    vecs.push_back(mk("c_7",     "7",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("c_0a",    "0",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("c_0b",    "0",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("c_0c",    "0",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("c_0d",    "0",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("c_sp",    " ",   1, 1, 1, PUSH, 4464, 1, 0, 0));
    vecs.push_back(mk("c_xfer",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    // '*' stalled, '1' dropped, then transfer; acc must still be 0
    vecs.push_back(mk("d_star",  "*",   1, 0, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("d_drop",  "1",   1, 0, 1, MUL,  0,  0, 1, 0));
    vecs.push_back(mk("d_hold1", 0,     0, 0, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("d_hold2", 0,     0, 0, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("d_hold3", 0,     0, 0, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("d_xfer",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("d_5",     "5",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("d_sp",    " ",   1, 1, 1, PUSH, 5,  0, 0, 0));
    vecs.push_back(mk("d_xdrop", "2",   1, 1, 0, PUSH, 0,  0, 1, 0));
    vecs.push_back(mk("d_idsp",  " ",   1, 1, 0, PUSH, 0,  0, 0, 0));
    // "45x" -> syntax error, then " " issues nothing
    vecs.push_back(mk("e_4",     "4",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("e_5",     "5",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("e_x",     "x",   1, 1, 0, PUSH, 0,  0, 0, 1));
    vecs.push_back(mk("e_sp",    " ",   1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("e_idle",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    // "8\r" stalled PUSH, LF ignored in IDLE, then '=' -> PRINT
    vecs.push_back(mk("g_8",     "8",   1, 0, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("g_cr",    8'h0D, 1, 0, 1, PUSH, 8,  0, 0, 0));
    vecs.push_back(mk("g_hold",  0,     0, 0, 1, PUSH, 8,  0, 0, 0));
    vecs.push_back(mk("g_xfer",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("g_lf",    8'h0A, 1, 1, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("g_eq",    "=",   1, 0, 1, PRINT, 0, 0, 0, 0));
    vecs.push_back(mk("g_prxf",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));
    // "6*" with stalls on both the PUSH and the MUL
    vecs.push_back(mk("h_6",     "6",   1, 0, 0, PUSH, 0,  0, 0, 0));
    vecs.push_back(mk("h_star",  "*",   1, 0, 1, PUSH, 6,  0, 0, 0));
    vecs.push_back(mk("h_hold",  0,     0, 0, 1, PUSH, 6,  0, 0, 0));
    vecs.push_back(mk("h_mul",   0,     0, 1, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("h_mhold", 0,     0, 0, 1, MUL,  0,  0, 0, 0));
    vecs.push_back(mk("h_xfer",  0,     0, 1, 0, PUSH, 0,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].data, vecs[i].rdy, vecs[i].crdy);
      check(vecs[i].name, pack_out(),
            {vecs[i].e_valid, vecs[i].e_op, vecs[i].e_val,
             vecs[i].e_ovf, vecs[i].e_ovr, vecs[i].e_syn});
    end

    // Reset while PUSH 99 waits: abandoned, then "7 " gives PUSH 7 only.
    drive_cycle("9", 1, 0);
    drive_cycle("9", 1, 0);
    drive_cycle(" ", 1, 0);
    check("f_wait99", pack_out(), {1'b1, PUSH, 16'd99, 1'b0, 1'b0, 1'b0});
    rx_ready = 1'b0;
    #5 rst = 1'b1;
    #1;
    check("f_rst_async", pack_out(), 23'd0);
    @(posedge clk); #1;
    check("f_rst_hold", pack_out(), 23'd0);
    rst = 1'b0;
    drive_cycle(0, 0, 1);
    check("f_no_stale", pack_out(), 23'd0);
    drive_cycle("7", 1, 1);
    check("f_7", pack_out(), 23'd0);
    drive_cycle(" ", 1, 1);
    check("f_push7", pack_out(), {1'b1, PUSH, 16'd7, 1'b0, 1'b0, 1'b0});
    drive_cycle(0, 0, 1);
    check("f_xfer", pack_out(), 23'd0);
    drive_cycle(0, 0, 1);
    check("f_quiet", pack_out(), 23'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rpn_token_parser.md
RPN_TOKEN_PARSER -- requirements
Module: rpn_token_parser

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits, legal range 8..32.
REQ-002 Port: clk  input  1  system clock, 25 MHz, shared with the UART receiver.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: rx_data  input  8  received byte, valid only while rx_ready is high.
REQ-005 Port: rx_ready  input  1  one-cycle strobe marking a new received byte.
REQ-006 Port: cmd_valid  output  1  command offered to the RPN engine.
REQ-007 Port: cmd_ready  input  1  engine accepts the command.
REQ-008 Port: cmd_op  output  3  opcode: PUSH=0, ADD=1, SUB=2, MUL=3, PRINT=4.
REQ-009 Port: cmd_value  output  WIDTH  operand for PUSH; all zeros for other opcodes.
REQ-010 Port: cmd_ovf  output  1  PUSH operand exceeded 2^WIDTH-1 and was truncated.
REQ-011 Port: overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-012 Port: syntax_err  output  1  one-cycle pulse when an illegal byte is received.

Function
REQ-013 States: IDLE, NUM, ISSUE_PUSH, ISSUE_OP; the state changes only on clk edges.
REQ-014 In IDLE or NUM, a digit byte (0x30..0x39) sets acc = acc*10 + (byte-0x30) mod 2^WIDTH, sets a sticky ovf flag if the exact result exceeds 2^WIDTH-1, and enters NUM on the following edge.
REQ-015 Delimiter bytes are 0x20, 0x0D and 0x0A: in NUM the block enters ISSUE_PUSH; in IDLE the byte is ignored with no pulse.
REQ-016 Operator bytes map as '+'(0x2B) to ADD, '-'(0x2D) to SUB, '*'(0x2A) to MUL and '='(0x3D) to PRINT.
REQ-017 An operator in IDLE latches pend_op and enters ISSUE_OP.
REQ-018 An operator in NUM latches pend_op and enters ISSUE_PUSH; ISSUE_OP follows that PUSH.
REQ-019 Any other byte in IDLE or NUM pulses syntax_err in the next cycle, clears acc, ovf and pend_op, and enters IDLE.
REQ-020 Latency: cmd_valid rises on the first edge after the rx_ready cycle.
REQ-021 cmd_valid is high exactly in ISSUE_PUSH and ISSUE_OP.
REQ-022 cmd_op, cmd_value and cmd_ovf hold stable while cmd_valid is high and cmd_ready is low.
REQ-023 A transfer occurs on an edge where cmd_valid and cmd_ready are both high; cmd_valid never depends combinationally on cmd_ready.
REQ-024 ISSUE_PUSH drives cmd_op=PUSH, cmd_value=acc and cmd_ovf=ovf.
REQ-025 On a transfer in ISSUE_PUSH: with pend_op set, the block enters ISSUE_OP with cmd_valid held high (back-to-back); otherwise it enters IDLE. acc and ovf clear in both cases.
REQ-026 ISSUE_OP drives cmd_op=pend_op, cmd_value=0 and cmd_ovf=0.
REQ-027 On a transfer in ISSUE_OP, the block clears pend_op and enters IDLE.
REQ-028 In ISSUE_* states, every rx_ready is dropped and overrun pulses in the next cycle, including on the transfer cycle.
REQ-029 A dropped byte does not affect acc, pend_op or the state.
REQ-030 overrun and syntax_err never assert in the same cycle.

Reset
REQ-031 While rst is high: state=IDLE, acc=0, ovf=0, pend_op=0, and cmd_valid, cmd_op, cmd_value, cmd_ovf, overrun and syntax_err are all 0, taking effect asynchronously.
REQ-032 Reset during ISSUE_* abandons the pending command; no transfer occurs after reset deasserts until new bytes arrive.
REQ-033 The first rx_ready sampled on the first edge after rst deasserts is processed normally.

Structure
REQ-034 Shared package rpn_pkg holds: opcode constants (PUSH, ADD, SUB, MUL, PRINT); ASCII constants for digits, delimiters and operators; the state encoding.
REQ-035 Sub-module rpn_dec_acc (combinational acc*10+digit built from shift-add, with an exact overflow flag) is instantiated once.

Verification
REQ-036 Bytes "12 " with cmd_ready=1 -> one transfer: PUSH, cmd_value=12, cmd_ovf=0; block returns to IDLE.
REQ-037 Bytes "3+" with cmd_ready=1 -> back-to-back transfers PUSH 3 then ADD on consecutive edges.
REQ-038 WIDTH=16, bytes "70000 " -> PUSH with cmd_value=4464 (70000 mod 65536) and cmd_ovf=1.
REQ-039 Byte '*' with cmd_ready=0 for 5 cycles and byte '1' strobed meanwhile -> cmd_valid held with MUL, one overrun pulse, acc stays 0; transfer occurs when cmd_ready rises.
REQ-040 Byte 'x' (0x78) after "45" -> syntax_err pulse, no command issued; then " " -> no command issued.
REQ-041 rst asserted while ISSUE_PUSH(99) waits -> cmd_valid low immediately; after release, bytes "7 " -> PUSH 7 only.
